// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR sequencer and its shift register.
package lfsr_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Default feedback masks, indexed by LFSR width.
  localparam logic [7:0] TAPS_8 = 8'h1D;

  // An all-zero seed would lock the LFSR, so it is replaced by this value.
  localparam int ZERO_SEED_SUB = 1;

endpackage : lfsr_pkg

// File: rtl/lfsr_sequencer_shiftreg.sv
// Right-shifting register with a synchronous seed load and a shift enable.
module ShiftRegister #(
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             init_i,
  input  logic [NBITS-1:0] seed_i,
  input  logic             enable_i,
  input  logic             shift_in_i,
  output logic [NBITS-1:0] q_o
);

  logic [NBITS-1:0] q_q, q_d;

  // A seed load takes priority over a shift.
  always_comb begin
    q_d = q_q;
    if (init_i) begin
      q_d = seed_i;
    end else if (enable_i) begin
      q_d = {shift_in_i, q_q[NBITS-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule : ShiftRegister

// File: rtl/lfsr_sequencer.sv
// Command-driven controller that seeds one Fibonacci LFSR and streams its states.
module lfsr_sequencer
  import lfsr_pkg::*;
#(
  parameter int               NBITS = 8,
  parameter logic [NBITS-1:0] TAPS  = TAPS_8,
  parameter int               CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [NBITS-1:0] cmd_seed,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] out_data,
  output logic             out_last,
  output logic             out_wrap,
  output logic             busy,
  output logic             zero_seed
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [NBITS-1:0] start_seed_q, start_seed_d;
  logic             zero_seed_q, zero_seed_d;

  logic             cmdFire;
  logic             loadRun;
  logic             outFire;
  logic [NBITS-1:0] effSeed;
  logic [NBITS-1:0] q;
  logic             feedback;

  assign cmdFire  = cmd_valid && cmd_ready;
  assign loadRun  = cmdFire && (cmd_len != '0);
  assign outFire  = out_valid && out_ready;
  assign effSeed  = (cmd_seed == '0) ? NBITS'(ZERO_SEED_SUB) : cmd_seed;
  assign feedback = ^(q & TAPS);

  ShiftRegister #(
    .NBITS(NBITS)
  ) uShiftRegister (
    .clk       (clk),
    .reset_n   (reset_n),
    .init_i    (loadRun),
    .seed_i    (effSeed),
    .enable_i  (outFire),
    .shift_in_i(feedback),
    .q_o       (q)
  );

  // Next-state logic; remaining floors at 1 and idx saturates so neither wraps.
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    idx_d        = idx_q;
    start_seed_d = start_seed_q;
    zero_seed_d  = zero_seed_q;
    if (cmdFire) begin
      zero_seed_d = (cmd_seed == '0);
    end
    case (state_q)
      IDLE: begin
        if (loadRun) begin
          state_d      = RUN;
          remaining_d  = cmd_len;
          idx_d        = '0;
          start_seed_d = effSeed;
        end
      end
      RUN: begin
        if (outFire) begin
          if (remaining_q != CNT_W'(1)) begin
            remaining_d = remaining_q - CNT_W'(1);
          end
          if (idx_q != '1) begin
            idx_d = idx_q + CNT_W'(1);
          end
          if (out_last) begin
            state_d = IDLE;
          end
        end
        if (abort) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      idx_q        <= '0;
      start_seed_q <= '0;
      zero_seed_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      idx_q        <= idx_d;
      start_seed_q <= start_seed_d;
      zero_seed_q  <= zero_seed_d;
    end
  end

  // Handshake outputs come from registered state; reset only masks cmd_ready.
  assign cmd_ready = reset_n && (state_q == IDLE);
  assign out_valid = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign out_data  = q;
  assign out_last  = (state_q == RUN) && (remaining_q == CNT_W'(1));
  assign out_wrap  = (state_q == RUN) && (q == start_seed_q) && (idx_q != '0);
  assign zero_seed = zero_seed_q;

endmodule : lfsr_sequencer

// File: tb/tb_lfsr_sequencer.sv
// Randomized self-checking bench for lfsr_sequencer against a word-level LFSR model.
module tb_lfsr_sequencer;

  localparam logic [7:0] TAPS = 8'h1D;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_seed;
  logic [15:0] cmd_len;
  logic        abort;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_wrap;
  logic        busy;
  logic        zero_seed;

  int compareCount  = 0;
  int mismatchCount = 0;
  logic [7:0] gotWords[$];

  always #5 clk = ~clk;

  lfsr_sequencer #(
    .NBITS(8),
    .TAPS (TAPS),
    .CNT_W(16)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_seed (cmd_seed),
    .cmd_len  (cmd_len),
    .abort    (abort),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .out_wrap (out_wrap),
    .busy     (busy),
    .zero_seed(zero_seed)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, required %0h", tag, observed, expected);
    end
  endtask

  // Successor state: shift right by one, new MSB is the parity of the tapped bits.
  function automatic logic [7:0] nextState(input logic [7:0] s);
    int parity;
    parity = $countones(s & TAPS) % 2;
    return (s >> 1) | (8'(parity) << 7);
  endfunction

  // One command plus its whole run; ready comes from pattern first, then random.
  task automatic applyStimulus(input logic [7:0] seed, input int len, input int readyPct,
                               input logic [15:0] pattern, input int patLen,
                               input int abortAfter, input logic idleAbort);
    logic [7:0] eff, s, seen;
    logic       rdy, stopNow;
    int         delivered, cycles, budget;
    gotWords.delete();
    @(negedge clk);
    checkOutput("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_seed  = seed;
    cmd_len   = len[15:0];
    abort     = idleAbort;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    abort     = 1'b0;
    checkOutput("zero_seed", 32'(zero_seed), 32'(seed == 8'h00));
    eff       = (seed == 8'h00) ? 8'h01 : seed;
    s         = eff;
    delivered = 0;
    cycles    = 0;
    budget    = 20 * len + 50;
    while (delivered < len) begin
      @(negedge clk);
      seen = out_data;
      checkOutput("out_valid", 32'(out_valid), 32'd1);
      checkOutput("busy", 32'(busy), 32'd1);
      checkOutput("cmd_ready_run", 32'(cmd_ready), 32'd0);
      checkOutput("out_data", 32'(out_data), 32'(s));
      checkOutput("out_last", 32'(out_last), 32'(delivered == len - 1));
      checkOutput("out_wrap", 32'(out_wrap), 32'(delivered != 0 && s == eff));
      if (cycles < patLen) rdy = pattern[cycles];
      else rdy = ($urandom_range(99) < readyPct);
      stopNow   = (delivered == abortAfter);
      out_ready = rdy;
      abort     = stopNow;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      abort     = 1'b0;
      cycles++;
      if (rdy) begin
        gotWords.push_back(seen);
        s = nextState(s);
        delivered++;
      end
      if (stopNow) break;
      if (cycles > budget) begin
        checkOutput("run_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(negedge clk);
    checkOutput("out_valid_after", 32'(out_valid), 32'd0);
    checkOutput("busy_after", 32'(busy), 32'd0);
    checkOutput("cmd_ready_after", 32'(cmd_ready), 32'd1);
  endtask

  task automatic checkWords(input string tag, input logic [7:0] expWords[$]);
    checkOutput({tag, "_count"}, 32'(gotWords.size()), 32'(expWords.size()));
    for (int i = 0; i < expWords.size() && i < gotWords.size(); i++) begin
      checkOutput(tag, 32'(gotWords[i]), 32'(expWords[i]));
    end
  endtask

  initial begin
    int len, abortAt;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_seed  = 8'h00;
    cmd_len   = 16'd0;
    abort     = 1'b0;
    out_ready = 1'b0;
    #2;
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_out_last", 32'(out_last), 32'd0);
    checkOutput("rst_out_wrap", 32'(out_wrap), 32'd0);
    checkOutput("rst_zero_seed", 32'(zero_seed), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    applyStimulus(8'h01, 6, 100, 16'h0000, 0, -1, 1'b0);
    checkWords("seq_basic", '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h88});

    applyStimulus(8'h00, 2, 100, 16'h0000, 0, -1, 1'b0);
    checkWords("seq_zero", '{8'h01, 8'h80});

    applyStimulus(8'h01, 256, 100, 16'h0000, 0, -1, 1'b0);
    checkOutput("wrap_word255", 32'(gotWords[255]), 32'h01);

    applyStimulus(8'h01, 4, 0, 16'h0059, 7, -1, 1'b0);
    checkWords("seq_stall", '{8'h01, 8'h80, 8'h40, 8'h20});

    applyStimulus(8'h01, 10, 100, 16'hFFFF, 16, 2, 1'b0);
    checkWords("seq_abort", '{8'h01, 8'h80, 8'h40});
    applyStimulus(8'h55, 0, 100, 16'h0000, 0, -1, 1'b1);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_seed  = 8'h00;
    cmd_len   = 16'd20;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    checkOutput("pre_reset_valid", 32'(out_valid), 32'd1);
    checkOutput("pre_reset_zero_seed", 32'(zero_seed), 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("midrst_out_last", 32'(out_last), 32'd0);
    checkOutput("midrst_zero_seed", 32'(zero_seed), 32'd0);
    out_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checkOutput("postrst_cmd_ready", 32'(cmd_ready), 32'd1);
    applyStimulus(8'h10, 2, 100, 16'h0000, 0, -1, 1'b0);
    checkWords("seq_postrst", '{8'h10, 8'h88});

    for (int n = 0; n < 12; n++) begin
      len     = ($urandom_range(3) == 0) ? 0 : int'($urandom_range(24, 1));
      abortAt = ($urandom_range(3) == 0) ? int'($urandom_range(len, 0)) : -1;
      applyStimulus(8'($urandom), len, int'($urandom_range(100, 30)), 16'h0000, 0,
                    abortAt, 1'($urandom_range(1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule : tb_lfsr_sequencer
